ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit: holds the program counter, issues word fetches to instruction memory over a request/ready/response handshake, and presents a stable 32-bit `instruction` to the decode stage. It sits directly upstream of `IDU_top` and consumes the decoder's `pc_increment` for PC-relative control flow. The CU sequences it with `fetch_start` and `pc_update`.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset and on trap redirect.
- TIMEOUT_CYCLES, 16, cycles in REQ+WAIT before a bus fault (used only with IFU_TIMEOUT_EN).

- soc_clk  input  1  system clock, all state on rising edge.
- IFU_reset_n  input  1  asynchronous, active-low reset.
- fetch_start  input  1  CU pulse: fetch the word at `pc`.
- pc_update  input  1  CU pulse: load next PC per `pc_sel`.
- pc_sel  input  2  00 PC+4, 01 PC+pc_increment, 10 {jalr_target[31:1],1'b0}, 11 RESET_PC.
- pc_increment  input  32  signed offset from IDU.
- jalr_target  input  32  absolute target from ALU.
- imem_ready  input  1  memory accepts the address this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- imem_err  input  1  qualifies `imem_rvalid`: response is an error.
- imem_req  output  1  address request.
- imem_addr  output  32  fetch address (equals `pc`).
- instruction  output  32  latched instruction to IDU.
- pc  output  32  current PC.
- fetch_done  output  1  one-cycle pulse, `instruction` updated.
- fetch_busy  output  1  high in REQ and WAIT.
- misaligned_fault  output  1  last fetch had pc[1:0]≠0.
- bus_fault  output  1  last fetch got imem_err or timed out.

## Operation
- FSM: IDLE, REQ, WAIT.
- IDLE: `fetch_start` with pc[1:0]==0 -> REQ; with pc[1:0]≠0 -> stay IDLE, no request, `instruction`←32'h0000_0013 (NOP), `misaligned_fault`←1, `fetch_done` pulse.
- REQ: `imem_req`=1, held until `imem_ready`; ready -> WAIT. `imem_rvalid` ignored in REQ.
- WAIT: `imem_rvalid` & !`imem_err` -> `instruction`←`imem_rdata`, pulse `fetch_done`, IDLE. `imem_rvalid` & `imem_err` -> `instruction`←NOP, `bus_fault`←1, pulse, IDLE.
- Fault flags hold until the next accepted `fetch_start`, which clears both.
- `pc_update` accepted only in IDLE; ignored elsewhere. All PC arithmetic modulo 2^32 (0xFFFF_FFFC+4 = 0).
- `fetch_start` and `pc_update` same IDLE cycle: PC update applied, `fetch_start` dropped.
- `fetch_start` outside IDLE ignored. `imem_rvalid` in IDLE ignored.
- `instruction` changes only with a `fetch_done` pulse.

## Timing
- Reset (async assert, any state): pc=RESET_PC, instruction=32'h0000_0013, FSM=IDLE, imem_req=0, fetch_done=0, fetch_busy=0, both faults=0; an in-flight fetch is abandoned.
- fetch_start sampled at edge k -> imem_req high after k. Zero-wait memory (ready in first REQ cycle, rvalid in first WAIT cycle) -> instruction and fetch_done valid after edge k+2; fetch_done low after k+3.
- Misaligned: fetch_done and fault high after edge k (1 cycle).
- pc_update at edge k -> new pc/imem_addr after edge k.

## Configuration
- IFU_TIMEOUT_EN defined: counter clears on REQ entry, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> NOP, bus_fault=1, fetch_done pulse, IDLE, imem_req dropped. Late response ignored.
- Undefined: no counter, waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- ifu_pkg: FSM state enum, pc_sel encodings (PC_SEL_SEQ, PC_SEL_REL, PC_SEL_JALR, PC_SEL_TRAP), NOP_INSTR constant.
- Sub-module ifu_pc_reg: next-PC mux plus PC register with reset to RESET_PC.

## Test plan
- Reset release, fetch_start, zero-wait memory returning 32'h123450B7 at addr 0 -> fetch_done 2 cycles later, instruction=32'h123450B7, pc=0.
- imem_ready low 3 cycles, rvalid 2 cycles later -> imem_req held 4 cycles, addr stable, fetch_done once.
- pc_update sel=01 with pc=0x100, pc_increment=0xFFFF_FFF0 -> pc=0xF0; sel=10 jalr_target=0x205 -> pc=0x204, fetch at 0x204.
- sel=10 jalr_target=0x206 then fetch_start -> no imem_req, misaligned_fault=1, instruction=0x00000013.
- imem_err with rvalid -> bus_fault=1, NOP; with IFU_TIMEOUT_EN, no rvalid for 16 cycles -> bus_fault, late rvalid ignored.
- IFU_reset_n asserted in WAIT -> imem_req=0, pc=RESET_PC immediately; subsequent rvalid ignored.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional fetch timeout is enabled with the IFU_TIMEOUT_EN macro (see ifu_fetch).
package ifu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } ifu_state_e;

   typedef enum logic [1:0] {
      PC_SEL_SEQ  = 2'b00,
      PC_SEL_REL  = 2'b01,
      PC_SEL_JALR = 2'b10,
      PC_SEL_TRAP = 2'b11
   } pc_sel_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register with its next-PC selection mux.
// All arithmetic wraps modulo 2^32; the register only moves when load_en_i is set.
module ifu_pc_reg
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_en_i,
   input  pc_sel_e     pc_sel_i,
   input  logic [31:0] pc_increment_i,
   input  logic [31:0] jalr_target_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      // NOTE: default assignment first so no latch is inferred on paths that skip the case.
      pc_d = pc_q;
      if (load_en_i) begin
         unique case (pc_sel_i)
            PC_SEL_SEQ:  pc_d = pc_q + PC_STEP;
            PC_SEL_REL:  pc_d = pc_q + pc_increment_i;
            PC_SEL_JALR: pc_d = {jalr_target_i[31:1], 1'b0};
            PC_SEL_TRAP: pc_d = RESET_PC;
            default:     pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, imem request/response handshake, latched instruction.
// Define IFU_TIMEOUT_EN to abort fetches that spend TIMEOUT_CYCLES in REQ+WAIT with a bus fault.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IFU_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
   input  logic        soc_clk,
   input  logic        IFU_reset_n,
   input  logic        fetch_start,
   input  logic        pc_update,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] pc_increment,
   input  logic [31:0] jalr_target,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        fetch_done,
   output logic        fetch_busy,
   output logic        misaligned_fault,
   output logic        bus_fault
);

   ifu_state_e  state_q;
   logic        req_q;
   logic        busy_q;
   logic        done_q;
   logic        misaligned_q;
   logic        bus_fault_q;
   logic [31:0] instr_q;
   logic        pc_load;
   logic        timeout_hit;

   // A PC update has priority over a same-cycle fetch_start and is honoured only in IDLE.
   assign pc_load = pc_update && (state_q == ST_IDLE);

   ifu_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (soc_clk),
      .rst_n          (IFU_reset_n),
      .load_en_i      (pc_load),
      .pc_sel_i       (pc_sel_e'(pc_sel)),
      .pc_increment_i (pc_increment),
      .jalr_target_i  (jalr_target),
      .pc_o           (pc)
   );

`ifdef IFU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;

   always_ff @(posedge soc_clk or negedge IFU_reset_n) begin
      if (!IFU_reset_n) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == ST_IDLE) || timeout_hit) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
   end

   assign timeout_hit = (state_q != ST_IDLE) &&
                        (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge soc_clk or negedge IFU_reset_n) begin
      if (!IFU_reset_n) begin
         state_q      <= ST_IDLE;
         req_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         bus_fault_q  <= 1'b0;
         instr_q      <= NOP_INSTR;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (fetch_start && !pc_update) begin
                  bus_fault_q <= 1'b0;
                  if (is_word_aligned(pc)) begin
                     state_q      <= ST_REQ;
                     req_q        <= 1'b1;
                     busy_q       <= 1'b1;
                     misaligned_q <= 1'b0;
                  end else begin
                     instr_q      <= NOP_INSTR;
                     misaligned_q <= 1'b1;
                     done_q       <= 1'b1;
                  end
               end
            end

            ST_REQ: begin
               if (timeout_hit) begin
                  state_q     <= ST_IDLE;
                  req_q       <= 1'b0;
                  busy_q      <= 1'b0;
                  instr_q     <= NOP_INSTR;
                  bus_fault_q <= 1'b1;
                  done_q      <= 1'b1;
               end else if (imem_ready) begin
                  state_q <= ST_WAIT;
                  req_q   <= 1'b0;
               end
            end

            ST_WAIT: begin
               // A response arriving in the final allowed cycle still wins over the timeout.
               if (imem_rvalid) begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  instr_q     <= imem_err ? NOP_INSTR : imem_rdata;
                  bus_fault_q <= imem_err;
               end else if (timeout_hit) begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  instr_q     <= NOP_INSTR;
                  bus_fault_q <= 1'b1;
                  done_q      <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req         = req_q;
   assign imem_addr        = pc;
   assign instruction      = instr_q;
   assign fetch_done       = done_q;
   assign fetch_busy       = busy_q;
   assign misaligned_fault = misaligned_q;
   assign bus_fault        = bus_fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed steps followed by randomized fetch/PC traffic
// checked against a behavioural model of the PC, instruction latch and fault flags.
module tb_ifu_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] RPC  = 32'h0000_0000;

   logic        soc_clk = 1'b0;
   logic        IFU_reset_n;
   logic        fetch_start;
   logic        pc_update;
   logic [1:0]  pc_sel;
   logic [31:0] pc_increment;
   logic [31:0] jalr_target;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        fetch_done;
   logic        fetch_busy;
   logic        misaligned_fault;
   logic        bus_fault;

   int n_vec    = 0;
   int n_err    = 0;
   int done_cnt = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_mis;
   logic        m_bus;

   ifu_fetch dut (
      .soc_clk          (soc_clk),
      .IFU_reset_n      (IFU_reset_n),
      .fetch_start      (fetch_start),
      .pc_update        (pc_update),
      .pc_sel           (pc_sel),
      .pc_increment     (pc_increment),
      .jalr_target      (jalr_target),
      .imem_ready       (imem_ready),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .imem_err         (imem_err),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .instruction      (instruction),
      .pc               (pc),
      .fetch_done       (fetch_done),
      .fetch_busy       (fetch_busy),
      .misaligned_fault (misaligned_fault),
      .bus_fault        (bus_fault)
   );

   always #5 soc_clk = ~soc_clk;

   // Counts every fetch_done pulse, sampled 2 time units after the rising edge.
   always @(posedge soc_clk) begin
      #2;
      if (fetch_done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge soc_clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ":pc"},    pc,               m_pc);
      check({tag, ":addr"},  imem_addr,        m_pc);
      check({tag, ":instr"}, instruction,      m_instr);
      check({tag, ":mis"},   misaligned_fault, m_mis);
      check({tag, ":bus"},   bus_fault,        m_bus);
      check({tag, ":busy"},  fetch_busy,       1'b0);
      check({tag, ":req"},   imem_req,         1'b0);
   endtask

   task automatic pc_upd(input logic [1:0] sel, input logic [31:0] inc, input logic [31:0] tgt);
      pc_update    = 1'b1;
      pc_sel       = sel;
      pc_increment = inc;
      jalr_target  = tgt;
      tick();
      pc_update = 1'b0;
      case (sel)
         2'd0: m_pc = m_pc + 32'd4;
         2'd1: m_pc = m_pc + inc;
         2'd2: m_pc = tgt & 32'hFFFF_FFFE;
         default: m_pc = RPC;
      endcase
      check("upd:pc",   pc,        m_pc);
      check("upd:addr", imem_addr, m_pc);
   endtask

   // One complete fetch; rdy_wait cycles of imem_ready low, val_wait empty WAIT cycles.
   // poke drives pc_update/fetch_start/rvalid during REQ, all of which must be ignored.
   task automatic do_fetch(input int rdy_wait, input int val_wait, input logic [31:0] data,
                           input logic err, input bit poke);
      int d0;
      d0 = done_cnt;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      if (m_pc % 4 != 0) begin
         m_instr = NOP;
         m_mis   = 1'b1;
         m_bus   = 1'b0;
         check("mis:done",  fetch_done,       1'b1);
         check("mis:flag",  misaligned_fault, 1'b1);
         check("mis:instr", instruction,      NOP);
         check("mis:req",   imem_req,         1'b0);
         tick();
         check("mis:done_low", fetch_done, 1'b0);
         check_idle("mis");
      end else begin
         m_mis = 1'b0;
         m_bus = 1'b0;
         check("f:req",    imem_req,         1'b1);
         check("f:busy",   fetch_busy,       1'b1);
         check("f:addr",   imem_addr,        m_pc);
         check("f:clrmis", misaligned_fault, 1'b0);
         check("f:clrbus", bus_fault,        1'b0);
         for (int i = 0; i < rdy_wait; i++) begin
            if (poke) begin
               pc_update   = 1'b1;
               pc_sel      = 2'd3;
               fetch_start = 1'b1;
               imem_rvalid = 1'b1;
               imem_rdata  = 32'hDEAD_BEEF;
            end
            tick();
            pc_update   = 1'b0;
            fetch_start = 1'b0;
            imem_rvalid = 1'b0;
            check("f:req_hold",  imem_req,  1'b1);
            check("f:addr_hold", imem_addr, m_pc);
         end
         imem_ready = 1'b1;
         tick();
         imem_ready = 1'b0;
         check("f:req_drop",  imem_req,   1'b0);
         check("f:wait_busy", fetch_busy, 1'b1);
         for (int j = 0; j < val_wait; j++) begin
            tick();
            check("f:wait_busy", fetch_busy, 1'b1);
         end
         imem_rvalid = 1'b1;
         imem_rdata  = data;
         imem_err    = err;
         tick();
         imem_rvalid = 1'b0;
         imem_err    = 1'b0;
         m_instr = err ? NOP : data;
         m_bus   = err;
         check("f:done",  fetch_done,  1'b1);
         check("f:instr", instruction, m_instr);
         check("f:bus",   bus_fault,   m_bus);
         tick();
         check("f:done_low", fetch_done, 1'b0);
         check_idle("f");
      end
      check("f:done_count", done_cnt - d0, 1);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] tgt;

      IFU_reset_n  = 1'b0;
      fetch_start  = 1'b0;
      pc_update    = 1'b0;
      pc_sel       = 2'd0;
      pc_increment = '0;
      jalr_target  = '0;
      imem_ready   = 1'b0;
      imem_rvalid  = 1'b0;
      imem_rdata   = '0;
      imem_err     = 1'b0;
      m_pc    = RPC;
      m_instr = NOP;
      m_mis   = 1'b0;
      m_bus   = 1'b0;

      tick();
      tick();
      check_idle("reset");
      check("reset:done", fetch_done, 1'b0);
      IFU_reset_n = 1'b1;
      tick();

      // Zero-wait fetch at address 0.
      do_fetch(0, 0, 32'h1234_50B7, 1'b0, 1'b0);

      // Slow memory: ready low for 3 cycles, rvalid 2 cycles into WAIT, with ignored pokes.
      do_fetch(3, 2, 32'hA5A5_0F0F, 1'b0, 1'b1);

      // rvalid while IDLE is ignored.
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hCAFE_F00D;
      tick();
      imem_rvalid = 1'b0;
      check("idle_rvalid:done", fetch_done, 1'b0);
      check_idle("idle_rvalid");

      // PC-relative, JALR and fetch at the new address.
      pc_upd(2'd2, 32'h0, 32'h0000_0100);
      pc_upd(2'd1, 32'hFFFF_FFF0, 32'h0);
      pc_upd(2'd2, 32'h0, 32'h0000_0205);
      do_fetch(1, 0, 32'h0000_0533, 1'b0, 1'b0);

      // Misaligned target, then recovery.
      pc_upd(2'd2, 32'h0, 32'h0000_0206);
      do_fetch(0, 0, 32'h0, 1'b0, 1'b0);
      pc_upd(2'd0, 32'h0, 32'h0);
      check("mis_hold", misaligned_fault, 1'b1);
      pc_upd(2'd2, 32'h0, 32'h0000_0300);
      do_fetch(0, 1, 32'h0040_0093, 1'b0, 1'b0);

      // Same-cycle fetch_start and pc_update: update wins, fetch dropped.
      r = done_cnt;
      fetch_start = 1'b1;
      pc_update   = 1'b1;
      pc_sel      = 2'd0;
      tick();
      fetch_start = 1'b0;
      pc_update   = 1'b0;
      m_pc = m_pc + 32'd4;
      check("both:req", imem_req, 1'b0);
      tick();
      check_idle("both");
      check("both:no_done", done_cnt - r, 0);

      // Wraparound and trap redirect.
      pc_upd(2'd2, 32'h0, 32'hFFFF_FFFD);
      pc_upd(2'd0, 32'h0, 32'h0);
      pc_upd(2'd2, 32'h0, 32'h0000_0800);
      pc_upd(2'd3, 32'h0, 32'h0);

      // Bus error response, then a clean fetch clears the flag.
      do_fetch(1, 1, 32'h1111_2222, 1'b1, 1'b0);
      tick();
      check("bus_hold", bus_fault, 1'b1);
      do_fetch(0, 0, 32'h0000_0073, 1'b0, 1'b0);

`ifdef IFU_TIMEOUT_EN
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("tmo:req", imem_req, 1'b1);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      repeat (14) tick();
      check("tmo:busy_before", fetch_busy, 1'b1);
      check("tmo:done_before", fetch_done, 1'b0);
      tick();
      m_instr = NOP;
      m_bus   = 1'b1;
      m_mis   = 1'b0;
      check("tmo:done",  fetch_done,  1'b1);
      check("tmo:bus",   bus_fault,   1'b1);
      check("tmo:instr", instruction, NOP);
      check("tmo:busy",  fetch_busy,  1'b0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h7777_7777;
      tick();
      imem_rvalid = 1'b0;
      check("tmo:late_done", fetch_done, 1'b0);
      check_idle("tmo:late");
`else
      do_fetch(2, 20, 32'h0FF0_0FF0, 1'b0, 1'b0);
`endif

      // Asynchronous reset while waiting for a response.
      pc_upd(2'd2, 32'h0, 32'h0000_0400);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check("rst:in_wait", fetch_busy, 1'b1);
      #2;
      IFU_reset_n = 1'b0;
      #1;
      m_pc    = RPC;
      m_instr = NOP;
      m_mis   = 1'b0;
      m_bus   = 1'b0;
      check_idle("rst:async");
      tick();
      IFU_reset_n = 1'b1;
      r = done_cnt;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h5555_AAAA;
      tick();
      imem_rvalid = 1'b0;
      tick();
      check("rst:late_done", done_cnt - r, 0);
      check_idle("rst:late");

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            tgt = $urandom;
            if ($urandom_range(0, 2) != 0) tgt[1] = 1'b0;
            pc_upd(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, tgt);
         end else begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                     ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
